parking_gate_ctrl: RTL and testbench

Sequencing controller that sits in front of the parking-lot occupancy counter. It watches two gate photo-sensors and decodes their pattern into single-cycle enter (cen) and exit (cex) pulses for the counter, one pulse per completed car passage. It uses the counter's full/empty status to drive the entry gate and to suppress impossible updates. It also flags aborted, stalled or illegal sensor sequences.

---
 rtl/parking_gate_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking gate sequencer: decodes the two photo-sensors into single-cycle enter/exit pulses
// for the occupancy counter, drives the entry gate, and flags aborted or illegal passages.
module parking_gate_ctrl #(
    parameter  int TIMEOUT = 1000,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_a,
    input  logic i_b,
    input  logic i_full,
    input  logic i_empty,
    output logic o_cen,
    output logic o_cex,
    output logic o_err,
    output logic o_gate_open,
    output logic o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E1,
        S_E2,
        S_E3,
        S_X1,
        S_X2,
        S_X3,
        S_WAIT_CLR
    } state_t;

    state_t          r_state;
    state_t          w_step_next;
    state_t          w_state_next;
    logic            r_a_meta;
    logic            r_a_s;
    logic            r_b_meta;
    logic            r_b_s;
    logic [TW-1:0]   r_timer;
    logic [1:0]      w_pat;
    logic            w_enter_done;
    logic            w_exit_done;
    logic            w_illegal;
    logic            w_timeout;
    logic            w_cen_d;
    logic            w_cex_d;
    logic            w_err_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_meta <= 1'b0;
            r_a_s    <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_s    <= 1'b0;
        end else begin
            r_a_meta <= i_a;
            r_a_s    <= r_a_meta;
            r_b_meta <= i_b;
            r_b_s    <= r_b_meta;
        end
    end

    assign w_pat = {r_a_s, r_b_s};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall timer only runs while a passage is in progress and the state holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if ((w_state_next != r_state) || (r_state == S_IDLE) || (r_state == S_WAIT_CLR)) begin
            r_timer <= '0;
        end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        w_step_next  = r_state;
        w_enter_done = 1'b0;
        w_exit_done  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (w_pat)
                    2'b00:   w_step_next = S_IDLE;
                    2'b10:   w_step_next = S_E1;
                    2'b01:   w_step_next = S_X1;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_E1: begin
                case (w_pat)
                    2'b10:   w_step_next = S_E1;
                    2'b11:   w_step_next = S_E2;
                    2'b00:   w_step_next = S_IDLE;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_E2: begin
                case (w_pat)
                    2'b11:   w_step_next = S_E2;
                    2'b01:   w_step_next = S_E3;
                    2'b10:   w_step_next = S_E1;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_E3: begin
                case (w_pat)
                    2'b01:   w_step_next = S_E3;
                    2'b00:   begin w_step_next = S_IDLE; w_enter_done = 1'b1; end
                    2'b11:   w_step_next = S_E2;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_X1: begin
                case (w_pat)
                    2'b01:   w_step_next = S_X1;
                    2'b11:   w_step_next = S_X2;
                    2'b00:   w_step_next = S_IDLE;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_X2: begin
                case (w_pat)
                    2'b11:   w_step_next = S_X2;
                    2'b10:   w_step_next = S_X3;
                    2'b01:   w_step_next = S_X1;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_X3: begin
                case (w_pat)
                    2'b10:   w_step_next = S_X3;
                    2'b00:   begin w_step_next = S_IDLE; w_exit_done = 1'b1; end
                    2'b11:   w_step_next = S_X2;
                    default: begin w_step_next = S_WAIT_CLR; w_illegal = 1'b1; end
                endcase
            end
            S_WAIT_CLR: begin
                w_step_next = (w_pat == 2'b00) ? S_IDLE : S_WAIT_CLR;
            end
            default: begin
                w_step_next = S_WAIT_CLR;
                w_illegal   = 1'b1;
            end
        endcase

        // A stalled passage is abandoned only when the sensors give no other move this cycle.
        w_timeout = (r_state != S_IDLE) && (r_state != S_WAIT_CLR) &&
                    (w_step_next == r_state) && (r_timer == TW'(TIMEOUT - 1));
        w_state_next = w_timeout ? S_WAIT_CLR : w_step_next;
    end

    always_comb begin
        w_cen_d = w_enter_done && !i_full;
        w_cex_d = w_exit_done && !i_empty;
        w_err_d = w_illegal || w_timeout ||
                  (w_enter_done && i_full) || (w_exit_done && i_empty);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cen       <= 1'b0;
            o_cex       <= 1'b0;
            o_err       <= 1'b0;
            o_gate_open <= 1'b1;
        end else begin
            o_cen       <= w_cen_d;
            o_cex       <= w_cex_d;
            o_err       <= w_err_d;
            o_gate_open <= ~i_full;
        end
    end

    assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: entry/exit passages, back-off, illegal jumps,
// stall timeout, full/empty suppression and asynchronous reset.
module tb_parking_gate_ctrl;

    logic clk;
    logic rstN;
    logic a;
    logic b;
    logic full;
    logic empty;
    logic cen;
    logic cex;
    logic err;
    logic gateOpen;
    logic busy;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cyc;
    int cenCount;
    int cexCount;
    int errCount;
    int firstCen;
    int firstErr;
    int firstBusy;

    parking_gate_ctrl #(.TIMEOUT(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_a         (a),
        .i_b         (b),
        .i_full      (full),
        .i_empty     (empty),
        .o_cen       (cen),
        .o_cex       (cex),
        .o_err       (err),
        .o_gate_open (gateOpen),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic resetCounters();
        cyc       = 0;
        cenCount  = 0;
        cexCount  = 0;
        errCount  = 0;
        firstCen  = -1;
        firstErr  = -1;
        firstBusy = -1;
    endtask

    // Advance n cycles, sampling outputs 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cen) cenCount++;
            if (cex) cexCount++;
            if (err) errCount++;
            if (cen && firstCen < 0) firstCen = cyc;
            if (err && firstErr < 0) firstErr = cyc;
            if (busy && firstBusy < 0) firstBusy = cyc;
        end
    endtask

    task automatic applyStimulus(input logic va, input logic vb, input int n);
        a = va;
        b = vb;
        step(n);
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic entrySeq();
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 5);
    endtask

    task automatic exitSeq();
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 5);
    endtask

    initial begin
        rstN  = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        full  = 1'b0;
        empty = 1'b0;
        resetCounters();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_cen", cen, 0);
        checkOutput("reset_cex", cex, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_gate_open", gateOpen, 1);
        checkOutput("reset_busy", busy, 0);
        rstN = 1'b1;

        $display("[TB] entry passage with exact pulse latency");
        resetCounters();
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("entry_no_early_cen", cenCount, 0);
        resetCounters();
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("entry_cen_count", cenCount, 1);
        checkOutput("entry_cen_latency", firstCen, 3);
        checkOutput("entry_cex_count", cexCount, 0);
        checkOutput("entry_err_count", errCount, 0);

        $display("[TB] exit passage, counter not empty");
        resetCounters();
        exitSeq();
        checkOutput("exit_cex_count", cexCount, 1);
        checkOutput("exit_cen_count", cenCount, 0);
        checkOutput("exit_err_count", errCount, 0);

        $display("[TB] exit passage, counter empty");
        empty = 1'b1;
        resetCounters();
        exitSeq();
        checkOutput("exit_empty_cex_count", cexCount, 0);
        checkOutput("exit_empty_err_count", errCount, 1);
        checkOutput("exit_empty_busy_end", busy, 0);
        empty = 1'b0;

        $display("[TB] car reverses out of the entry");
        resetCounters();
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("backoff_busy_before_sync", busy, 1);
        step(1);
        checkOutput("backoff_busy_after_sync", busy, 0);
        step(2);
        checkOutput("backoff_cen_count", cenCount, 0);
        checkOutput("backoff_err_count", errCount, 0);

        $display("[TB] illegal jump then recovery");
        resetCounters();
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("illegal_err_count", errCount, 1);
        checkOutput("illegal_cen_count", cenCount, 0);
        checkOutput("illegal_cex_count", cexCount, 0);
        checkOutput("illegal_busy_waitclr", busy, 1);
        resetCounters();
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("waitclr_exit_cen", cenCount, 0);
        checkOutput("waitclr_exit_busy", busy, 0);
        resetCounters();
        entrySeq();
        checkOutput("recovery_cen_count", cenCount, 1);
        checkOutput("recovery_err_count", errCount, 0);

        $display("[TB] stall timeout with TIMEOUT=8");
        resetCounters();
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("timeout_enter_e1_cycle", firstBusy, 3);
        checkOutput("timeout_err_cycle", firstErr, 11);
        checkOutput("timeout_err_count", errCount, 1);
        checkOutput("timeout_busy_waitclr", busy, 1);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("timeout_cleared_busy", busy, 0);

        $display("[TB] entry with counter full");
        full = 1'b1;
        checkOutput("full_gate_open_lag", gateOpen, 1);
        step(1);
        checkOutput("full_gate_closed", gateOpen, 0);
        resetCounters();
        entrySeq();
        checkOutput("full_cen_count", cenCount, 0);
        checkOutput("full_err_count", errCount, 1);
        checkOutput("full_busy_end", busy, 0);

        $display("[TB] reset mid-sequence");
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("midreset_busy_in_e2", busy, 1);
        a    = 1'b0;
        b    = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_gate_open", gateOpen, 1);
        checkOutput("midreset_cen", cen, 0);
        checkOutput("midreset_err", err, 0);
        full = 1'b0;
        #2;
        rstN = 1'b1;
        resetCounters();
        step(6);
        checkOutput("postreset_cen_count", cenCount, 0);
        checkOutput("postreset_err_count", errCount, 0);
        checkOutput("postreset_busy", busy, 0);
        checkOutput("postreset_gate_open", gateOpen, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
